// File: rtl/hazard_ctrl_pkg.sv
// hazard_pkg: shared opcodes, register constants, mul/div sequencer
// state type and the load-use match helper for the hazard controller.
package hazard_pkg;

  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  // A load in EX whose destination feeds a source of the ID instruction.
  // Writes to $zero never create a real dependency.
  function automatic logic is_load_use(
    input logic [5:0] opcode_ex,
    input logic [4:0] rt_ex,
    input logic [4:0] rs_id,
    input logic [4:0] rt_id,
    input logic       uses_rt_id
  );
    return (opcode_ex == OP_LW) && (rt_ex != REG_ZERO) &&
           ((rt_ex == rs_id) || (uses_rt_id && (rt_ex == rt_id)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-side bundle of hazard inputs and control outputs.
// The master modport is the pipeline/datapath side, slave is hazard_ctrl.
// Optional macro HAZARD_PERF_CNT_EN adds the stall/flush counter outputs.
interface hazard_ctrl_if
`ifdef HAZARD_PERF_CNT_EN
  #(parameter int CNT_W = 32)
`endif
  ;
  logic [5:0] opcode_ex;
  logic [4:0] rt_ex;
  logic [4:0] rs_id;
  logic [4:0] rt_id;
  logic       uses_rt_id;
  logic       branch_taken_ex;
  logic       md_start_ex;

  logic       pc_write;
  logic       if_id_write;
  logic       id_ex_bubble;
  logic       if_id_flush;
  logic       ex_hold;
  logic       md_busy;
  logic       md_done;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
`endif

  modport master (
    output opcode_ex, rt_ex, rs_id, rt_id, uses_rt_id, branch_taken_ex, md_start_ex,
    input  pc_write, if_id_write, id_ex_bubble, if_id_flush, ex_hold, md_busy, md_done
`ifdef HAZARD_PERF_CNT_EN
    , input stall_cnt, flush_cnt
`endif
  );

  modport slave (
    input  opcode_ex, rt_ex, rs_id, rt_id, uses_rt_id, branch_taken_ex, md_start_ex,
    output pc_write, if_id_write, id_ex_bubble, if_id_flush, ex_hold, md_busy, md_done
`ifdef HAZARD_PERF_CNT_EN
    , output stall_cnt, flush_cnt
`endif
  );

endinterface

// File: rtl/hazard_ctrl_md_sequencer.sv
// md_sequencer: tracks how long a multi-cycle mul/div instruction occupies
// EX. IDLE -> BUSY on start, count down MD_LATENCY-2 .. 0, then one DONE
// cycle in which the result is valid and the instruction leaves EX.
module md_sequencer
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = 8
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      md_start_ex,
  output md_state_t state,
  output logic      md_busy,
  output logic      md_done
);

  localparam int            CW       = $clog2(MD_LATENCY);
  localparam logic [CW-1:0] CNT_INIT = CW'(MD_LATENCY - 2);

  if (MD_LATENCY < 2 || MD_LATENCY > 64) begin : g_bad_latency
    $error("md_sequencer: MD_LATENCY must be in 2..64");
  end

  md_state_t     state_q, state_d;
  logic [CW-1:0] md_cnt_q, md_cnt_d;

  // State and occupancy counter registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  // Next state: the DONE cycle never re-arms, because a start seen there is
  // still the finishing instruction rather than a new one.
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    case (state_q)
      IDLE: begin
        if (md_start_ex) begin
          state_d  = BUSY;
          md_cnt_d = CNT_INIT;
        end
      end
      BUSY: begin
        if (md_cnt_q == '0) begin
          state_d = DONE;
        end else begin
          md_cnt_d = md_cnt_q - CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        md_cnt_d = '0;
      end
    endcase
  end

  // Occupancy flags: the start cycle itself already counts as busy.
  always_comb begin
    md_busy = (state_q == BUSY) || ((state_q == IDLE) && md_start_ex);
    md_done = (state_q == DONE);
  end

  assign state = state_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: central hazard controller for the 5-stage MIPS pipeline.
// Merges mul/div occupancy, taken-branch flush and load-use stall into the
// PC / IF/ID / ID/EX enables and bubble/flush controls.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall/flush counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = 8
`ifdef HAZARD_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hif
);

  md_state_t md_state;
  logic      md_busy;
  logic      md_done;
  logic      md_hold;
  logic      load_use;

  logic pc_write;
  logic if_id_write;
  logic id_ex_bubble;
  logic if_id_flush;
  logic ex_hold;

  md_sequencer #(
    .MD_LATENCY (MD_LATENCY)
  ) u_md_seq (
    .clk         (clk),
    .rst         (rst),
    .md_start_ex (hif.md_start_ex),
    .state       (md_state),
    .md_busy     (md_busy),
    .md_done     (md_done)
  );

  // Priority resolution: mul/div occupancy beats branch flush beats load-use.
  always_comb begin
    md_hold      = (md_state == BUSY) || ((md_state == IDLE) && hif.md_start_ex);
    load_use     = is_load_use(hif.opcode_ex, hif.rt_ex, hif.rs_id, hif.rt_id, hif.uses_rt_id);
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    ex_hold      = 1'b0;
    if (md_hold) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      ex_hold     = 1'b1;
    end else if (hif.branch_taken_ex) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  assign hif.pc_write     = pc_write;
  assign hif.if_id_write  = if_id_write;
  assign hif.id_ex_bubble = id_ex_bubble;
  assign hif.if_id_flush  = if_id_flush;
  assign hif.ex_hold      = ex_hold;
  assign hif.md_busy      = md_busy;
  assign hif.md_done      = md_done;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Counter increments, holding at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (if_id_flush && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // Performance counter registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hif.stall_cnt = stall_cnt_q;
  assign hif.flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed test of hazard_ctrl against a time-based
// behavioural model, plus hand-computed literal checks.
// Output vector bit order: {pc_write, if_id_write, id_ex_bubble,
// if_id_flush, ex_hold, md_busy, md_done}.
module tb_hazard_ctrl;

  localparam int MD_LAT = 8;
`ifdef HAZARD_PERF_CNT_EN
  localparam int TB_CNT_W = 4;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;
`endif

  logic clk;
  logic rst;

  int n_vec  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  // model state: cycle number and start cycle of the active mul/div (-1 = none)
  int cyc     = 0;
  int m_t0    = -1;
  int m_stall = 0;
  int m_flush = 0;

`ifdef HAZARD_PERF_CNT_EN
  hazard_ctrl_if #(.CNT_W(TB_CNT_W)) hif ();
  hazard_ctrl #(.MD_LATENCY(MD_LAT), .CNT_W(TB_CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hif (hif)
  );
`else
  hazard_ctrl_if hif ();
  hazard_ctrl #(.MD_LATENCY(MD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .hif (hif)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] dut_vec();
    return {hif.pc_write, hif.if_id_write, hif.id_ex_bubble, hif.if_id_flush,
            hif.ex_hold, hif.md_busy, hif.md_done};
  endfunction

  // Expected outputs from the rules: a mul/div started at cycle t0 holds EX
  // for cycles t0..t0+MD_LAT-1 and reports done at t0+MD_LAT.
  function automatic logic [6:0] model_vec();
    int   age;
    logic hold;
    logic done;
    logic lu;
    age  = (m_t0 >= 0) ? (cyc - m_t0) : -1;
    hold = ((m_t0 < 0) && hif.md_start_ex) || ((m_t0 >= 0) && (age < MD_LAT));
    done = (m_t0 >= 0) && (age == MD_LAT);
    lu   = (hif.opcode_ex == 6'd35) && (hif.rt_ex != 5'd0) &&
           ((hif.rt_ex == hif.rs_id) || (hif.uses_rt_id && (hif.rt_ex == hif.rt_id)));
    if (hold)                     return 7'b0000110;
    else if (hif.branch_taken_ex) return {6'b111100, done};
    else if (lu)                  return {6'b001000, done};
    else                          return {6'b110000, done};
  endfunction

  // Advance the model at each clock edge using the inputs of the ending cycle.
  always @(posedge clk) begin
    logic [6:0] v;
    v = model_vec();
    if (rst) begin
      m_t0    = -1;
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (!v[6]) m_stall = (m_stall < 2**30) ? m_stall + 1 : m_stall;
      if (v[3])  m_flush = (m_flush < 2**30) ? m_flush + 1 : m_flush;
`ifdef HAZARD_PERF_CNT_EN
      if (m_stall > CNT_MAX) m_stall = CNT_MAX;
      if (m_flush > CNT_MAX) m_flush = CNT_MAX;
`endif
      if ((m_t0 < 0) && hif.md_start_ex)                m_t0 = cyc;
      else if ((m_t0 >= 0) && (cyc - m_t0 >= MD_LAT))   m_t0 = -1;
    end
    cyc = cyc + 1;
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [6:0] exp_v;
    logic [6:0] act_v;
    if (chk_en) begin
      exp_v = model_vec();
      act_v = dut_vec();
      n_vec = n_vec + 1;
      if (act_v !== exp_v) begin
        n_fail = n_fail + 1;
        $display("[TB] FAIL model_cycle%0d got %b want %b", cyc, act_v, exp_v);
      end
`ifdef HAZARD_PERF_CNT_EN
      n_vec = n_vec + 1;
      if (int'(hif.stall_cnt) != m_stall || int'(hif.flush_cnt) != m_flush) begin
        n_fail = n_fail + 1;
        $display("[TB] FAIL model_counters cycle%0d got stall=%0d flush=%0d want stall=%0d flush=%0d",
                 cyc, hif.stall_cnt, hif.flush_cnt, m_stall, m_flush);
      end
`endif
    end
  end

  // Drive one cycle of inputs just after the edge, then wait for mid-cycle.
  task automatic applyStimulus(input logic [5:0] opc, input logic [4:0] rte,
                               input logic [4:0] rsi, input logic [4:0] rti,
                               input logic ur, input logic br, input logic md,
                               input logic r);
    @(posedge clk);
    #1;
    hif.opcode_ex       = opc;
    hif.rt_ex           = rte;
    hif.rs_id           = rsi;
    hif.rt_id           = rti;
    hif.uses_rt_id      = ur;
    hif.branch_taken_ex = br;
    hif.md_start_ex     = md;
    rst                 = r;
    @(negedge clk);
  endtask

  task automatic quiet();
    applyStimulus(6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    n_vec = n_vec + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("[TB] FAIL %s got 'h%0h want 'h%0h", name, act, exp);
    end
  endtask

  initial begin
    rst                 = 1'b1;
    hif.opcode_ex       = '0;
    hif.rt_ex           = '0;
    hif.rs_id           = '0;
    hif.rt_id           = '0;
    hif.uses_rt_id      = 1'b0;
    hif.branch_taken_ex = 1'b0;
    hif.md_start_ex     = 1'b0;

    applyStimulus(6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;

    // reset state with quiet inputs
    quiet();
    checkOutput("reset_outputs", int'(dut_vec()), 'b1100000);

    // load-use through rs
    applyStimulus(6'd35, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_rs", int'(dut_vec()), 'b0010000);
    // load-use through rt
    applyStimulus(6'd35, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_rt", int'(dut_vec()), 'b0010000);
    // rt not a source
    applyStimulus(6'd35, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_rt_unused", int'(dut_vec()), 'b1100000);
    // destination $zero
    applyStimulus(6'd35, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_zero", int'(dut_vec()), 'b1100000);
    // not a load
    applyStimulus(6'd43, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_not_lw", int'(dut_vec()), 'b1100000);
    // branch beats load-use
    applyStimulus(6'd35, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("branch_over_lu", int'(dut_vec()), 'b1111000);

    // mul/div: hold T..T+7, done at T+8 (start still asserted there), idle at T+9
    applyStimulus(6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("md_start", int'(dut_vec()), 'b0000110);
    for (int i = 1; i < MD_LAT; i++) begin
      applyStimulus((i == 3) ? 6'd35 : 6'd0, 5'd5, 5'd5, 5'd0, 1'b0, (i == 2), 1'b1, 1'b0);
      checkOutput($sformatf("md_hold_%0d", i), int'(dut_vec()), 'b0000110);
    end
    applyStimulus(6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("md_done", int'(dut_vec()), 'b1100001);
    quiet();
    checkOutput("md_idle_after", int'(dut_vec()), 'b1100000);

    // branch during DONE flushes normally
    applyStimulus(6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i < MD_LAT; i++) begin
      applyStimulus(6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    applyStimulus(6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("md_done_branch", int'(dut_vec()), 'b1111001);
    quiet();

    // reset at T+3 aborts the mul/div with no done pulse
    applyStimulus(6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("md_rst_cycle", int'(dut_vec()), 'b0000110);
    quiet();
    checkOutput("md_after_rst", int'(dut_vec()), 'b1100000);
    for (int i = 0; i < MD_LAT + 2; i++) begin
      quiet();
      checkOutput($sformatf("md_no_done_%0d", i), int'(hif.md_done), 0);
    end

`ifdef HAZARD_PERF_CNT_EN
    // 3 load-use stalls and 1 branch after a reset
    applyStimulus(6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(6'd35, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    quiet();
    checkOutput("stall_cnt_3", int'(hif.stall_cnt), 3);
    checkOutput("flush_cnt_1", int'(hif.flush_cnt), 1);
    // 14 more stalls: 17 saturates at 15 for a 4-bit counter
    for (int i = 0; i < 14; i++) begin
      applyStimulus(6'd35, 5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    quiet();
    checkOutput("stall_cnt_sat", int'(hif.stall_cnt), 15);
    checkOutput("flush_cnt_keep", int'(hif.flush_cnt), 1);
`endif

    quiet();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
